lsu: RTL and testbench

Load-store unit between the execute stage and the byte-addressed data memory. It accepts one load/store request at a time over a valid/ready handshake and decodes the address into either the 64 KiB data memory or three memory-mapped I/O words. It drives the memory's address, write data, byte mask and write enable, and returns sign- or zero-extended load data with a fixed two-cycle latency.

---
 rtl/lsu_pkg.sv | 66 ++++++
 rtl/lsu_load_ext.sv | 22 ++
 rtl/lsu.sv | 149 ++++++++++++++
 tb/tb_lsu.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load-store unit: funct3 encodings,
// FSM states, I/O map, byte-lane masks and small lane helpers.
package lsu_pkg;

  // Load encodings. Stores reuse the same width encodings, so the store
  // names are aliases rather than separate enum members.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } funct3_e;

  localparam funct3_e SB = LB;
  localparam funct3_e SH = LH;
  localparam funct3_e SW = LW;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  // Memory-mapped I/O words
  localparam logic [31:0] LEDR_ADDR   = 32'h1000_0000;
  localparam logic [31:0] LEDG_ADDR   = 32'h1000_1000;
  localparam logic [31:0] SWITCH_ADDR = 32'h1001_0000;

  // Byte-lane masks, always low-lane aligned
  localparam logic [3:0] MASK_NONE = 4'b0000;
  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;

  // Request captured on the accept cycle
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } req_t;

  // Access width as a lane mask; MASK_NONE flags an illegal funct3.
  function automatic logic [3:0] width_mask(input logic [2:0] funct3);
    case (funct3)
      LB, LBU: return MASK_B;
      LH, LHU: return MASK_H;
      LW:      return MASK_W;
      default: return MASK_NONE;
    endcase
  endfunction

  // Replace only the byte lanes selected by mask.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                              input logic [31:0] data,
                                              input logic [3:0]  mask);
    logic [31:0] result;
    result = old;
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) result[8*i +: 8] = data[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of a low-lane aligned raw load word by funct3.
module lsu_load_ext
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  // Extend byte/half loads from their top bit or with zeros; words pass through
  always_comb begin
    data = raw;
    case (funct3)
      LB:      data = {{24{raw[7]}}, raw[7:0]};
      LH:      data = {{16{raw[15]}}, raw[15:0]};
      LBU:     data = {24'h0, raw[7:0]};
      LHU:     data = {16'h0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load-store unit: one request at a time, IDLE -> ACCESS -> RESP, decoding
// into a byte-addressed data memory or three memory-mapped I/O words.
module lsu
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  input  logic [2:0]        i_req_funct3,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_mask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata,
  input  logic [31:0]       i_io_sw,
  output logic [31:0]       o_io_ledr,
  output logic [31:0]       o_io_ledg
);

  state_e      state, state_next;
  req_t        req;
  logic [31:0] ledr, ledg;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [3:0]  mask;
  logic        misaligned;
  logic        hit_mem, hit_ledr, hit_ledg, hit_switch;
  logic        err;
  logic        io_write;
  logic [31:0] raw;
  logic [31:0] ext;

  // State register
  always_ff @(posedge i_clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!i_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state logic: a request is taken only from IDLE
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves
    // state_next unassigned and infers a latch.
    state_next = state;
    case (state)
      IDLE:    if (i_req_valid) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and memory-port outputs; the memory bus is idle-zero outside ACCESS
  always_comb begin
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_mask  = MASK_NONE;
    o_mem_wren  = 1'b0;
    case (state)
      IDLE:   o_req_ready = 1'b1;
      ACCESS: begin
        o_mem_addr  = req.addr[MEM_AW-1:0];
        o_mem_wdata = req.wdata;
        o_mem_mask  = mask;
        // Reset gates the write in the same cycle so a dropped store never lands
        o_mem_wren  = req.we & hit_mem & ~err & i_reset_n;
      end
      RESP:    o_rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Capture the request on the accept cycle
  always_ff @(posedge i_clk) begin
    if (!i_reset_n)                          req <= '0;
    else if (state == IDLE && i_req_valid)   req <= {i_req_we, i_req_addr, i_req_wdata, i_req_funct3};
  end

  // Decode the captured request: width, alignment, target and error
  always_comb begin
    mask       = width_mask(req.funct3);
    misaligned = ((mask == MASK_H) & req.addr[0]) |
                 ((mask == MASK_W) & (req.addr[1:0] != 2'b00));
    hit_mem    = (req.addr[31:MEM_AW] == '0);
    hit_ledr   = (req.addr == LEDR_ADDR);
    hit_ledg   = (req.addr == LEDG_ADDR);
    hit_switch = (req.addr == SWITCH_ADDR);
    err        = (mask == MASK_NONE) | misaligned |
                 ~(hit_mem | hit_ledr | hit_ledg | hit_switch) |
                 (hit_switch & req.we);
    io_write   = (state == ACCESS) & req.we & ~err;
  end

  // Select the raw load source for the decoded target
  always_comb begin
    raw = '0;
    if (hit_mem)         raw = i_mem_rdata;
    else if (hit_ledr)   raw = ledr;
    else if (hit_ledg)   raw = ledg;
    else if (hit_switch) raw = i_io_sw;
  end

  lsu_load_ext u_load_ext (
    .funct3 (req.funct3),
    .raw    (raw),
    .data   (ext)
  );

  // Response register, loaded at the end of ACCESS; stores and errors read 0
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (state == ACCESS) begin
      rsp_err   <= err;
      rsp_rdata <= (err | req.we) ? '0 : ext;
    end
  end

  // LED registers take masked byte-lane stores at the end of ACCESS
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      ledr <= '0;
      ledg <= '0;
    end else begin
      if (io_write && hit_ledr) ledr <= merge_lanes(ledr, req.wdata, mask);
      if (io_write && hit_ledg) ledg <= merge_lanes(ledg, req.wdata, mask);
    end
  end

  assign o_rsp_rdata = rsp_rdata;
  assign o_rsp_err   = rsp_err;
  assign o_io_ledr   = ledr;
  assign o_io_ledg   = ledg;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: table of request vectors with a response scoreboard, a
// behavioural byte memory, and hand-written reset and busy-request sequences.
module tb_lsu;
  import lsu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_we;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [2:0]  i_req_funct3;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [15:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        o_mem_wren;
  logic [31:0] i_mem_rdata;
  logic [31:0] i_io_sw;
  logic [31:0] o_io_ledr;
  logic [31:0] o_io_ledg;

  lsu #(.MEM_AW(16)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .i_req_funct3 (i_req_funct3),
    .o_rsp_valid  (o_rsp_valid),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_mask   (o_mem_mask),
    .o_mem_wren   (o_mem_wren),
    .i_mem_rdata  (i_mem_rdata),
    .i_io_sw      (i_io_sw),
    .o_io_ledr    (o_io_ledr),
    .o_io_ledg    (o_io_ledg)
  );

  always #5 i_clk = ~i_clk;

  // Vector: request plus everything expected from it
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [3:0]  mask;
    logic        wren;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] ledr;
    logic [31:0] ledg;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          id;
  } sb_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];
  sb_t  sb [$];
  sb_t  mon_e;

  int n_tests  = 0;
  int n_fail   = 0;
  int wren_cnt = 0;
  int rsp_cnt  = 0;
  int push_cnt = 0;

  bit [7:0] mem [0:65535];

  // Behavioural data memory: combinational masked read, clocked masked write
  always_comb begin
    i_mem_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (o_mem_mask[i]) i_mem_rdata[8*i +: 8] = mem[o_mem_addr + 16'(i)];
    end
  end

  always @(posedge i_clk) begin
    if (o_mem_wren) begin
      for (int i = 0; i < 4; i++) begin
        if (o_mem_mask[i]) mem[o_mem_addr + 16'(i)] <= o_mem_wdata[8*i +: 8];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Response monitor: every pulse must match the oldest outstanding request
  always @(negedge i_clk) begin
    if (o_mem_wren) wren_cnt <= wren_cnt + 1;
    if (o_rsp_valid) begin
      rsp_cnt <= rsp_cnt + 1;
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("t%0d_rdata", mon_e.id), o_rsp_rdata, mon_e.rdata);
        check($sformatf("t%0d_err", mon_e.id), 32'(o_rsp_err), 32'(mon_e.err));
      end
    end
  end

  function automatic vec_t mk(logic we, logic [31:0] addr, logic [31:0] wdata, logic [2:0] f3,
                              logic [3:0] mask, logic wren, logic [31:0] rdata, logic err,
                              logic [31:0] ledr, logic [31:0] ledg);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3; v.mask = mask;
    v.wren = wren; v.rdata = rdata; v.err = err; v.ledr = ledr; v.ledg = ledg;
    return v;
  endfunction

  // One full transaction; poke drives a bogus request while the unit is busy
  task automatic do_req(input int id, input vec_t v, input bit poke, output int waited);
    int lat;
    int w0;
    waited = 0;
    while (!o_req_ready && waited < 8) begin
      @(posedge i_clk); #1;
      waited++;
    end
    check($sformatf("t%0d_ready", id), 32'(o_req_ready), 32'd1);
    i_req_valid  = 1'b1;
    i_req_we     = v.we;
    i_req_addr   = v.addr;
    i_req_wdata  = v.wdata;
    i_req_funct3 = v.f3;
    sb.push_back('{v.rdata, v.err, id});
    push_cnt++;
    w0 = wren_cnt;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    check($sformatf("t%0d_acc_ready", id), 32'(o_req_ready), 32'd0);
    check($sformatf("t%0d_acc_mask", id), 32'(o_mem_mask), 32'(v.mask));
    check($sformatf("t%0d_acc_addr", id), 32'(o_mem_addr), {16'h0, v.addr[15:0]});
    check($sformatf("t%0d_acc_wdata", id), o_mem_wdata, v.wdata);
    check($sformatf("t%0d_acc_wren", id), 32'(o_mem_wren), 32'(v.wren));
    if (poke) begin
      i_req_valid  = 1'b1;
      i_req_we     = 1'b0;
      i_req_addr   = 32'h0000_0100;
      i_req_funct3 = LW;
    end
    lat = 1;
    while (!o_rsp_valid && lat < 6) begin
      @(posedge i_clk); #1;
      lat++;
    end
    i_req_valid = 1'b0;
    check($sformatf("t%0d_latency", id), 32'(lat), 32'd2);
    check($sformatf("t%0d_rsp_wren", id), 32'(o_mem_wren), 32'd0);
    check($sformatf("t%0d_rsp_mask", id), 32'(o_mem_mask), 32'd0);
    check($sformatf("t%0d_ledr", id), o_io_ledr, v.ledr);
    check($sformatf("t%0d_ledg", id), o_io_ledg, v.ledg);
    check($sformatf("t%0d_wren_cycles", id), 32'(wren_cnt - w0), 32'(v.wren));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: reached 200000 ns without finishing, want summary earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int   waited;
    int   w0;
    vec_t v;

    //          we    addr          wdata         f3      mask  wren rdata         err   ledr          ledg
    vecs[0]  = mk(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, SW,    4'hF, 1'b1, 32'h0000_0000, 1'b0, 32'h0,        32'h0);
    vecs[1]  = mk(1'b0, 32'h0000_0100, 32'h0,         LW,    4'hF, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0,        32'h0);
    vecs[2]  = mk(1'b1, 32'h0000_0203, 32'h0000_0080, SB,    4'h1, 1'b1, 32'h0000_0000, 1'b0, 32'h0,        32'h0);
    vecs[3]  = mk(1'b0, 32'h0000_0203, 32'h0,         LB,    4'h1, 1'b0, 32'hFFFF_FF80, 1'b0, 32'h0,        32'h0);
    vecs[4]  = mk(1'b0, 32'h0000_0203, 32'h0,         LBU,   4'h1, 1'b0, 32'h0000_0080, 1'b0, 32'h0,        32'h0);
    vecs[5]  = mk(1'b0, 32'h0000_0101, 32'h0,         LH,    4'h3, 1'b0, 32'h0000_0000, 1'b1, 32'h0,        32'h0);
    vecs[6]  = mk(1'b1, 32'h0000_0102, 32'h1111_1111, SW,    4'hF, 1'b0, 32'h0000_0000, 1'b1, 32'h0,        32'h0);
    vecs[7]  = mk(1'b0, 32'h0000_0100, 32'h0,         LW,    4'hF, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0,        32'h0);
    vecs[8]  = mk(1'b0, 32'h0000_0102, 32'h0,         LH,    4'h3, 1'b0, 32'hFFFF_DEAD, 1'b0, 32'h0,        32'h0);
    vecs[9]  = mk(1'b0, 32'h0000_0100, 32'h0,         LHU,   4'h3, 1'b0, 32'h0000_BEEF, 1'b0, 32'h0,        32'h0);
    vecs[10] = mk(1'b1, 32'h0000_0204, 32'h0000_ABCD, SH,    4'h3, 1'b1, 32'h0000_0000, 1'b0, 32'h0,        32'h0);
    vecs[11] = mk(1'b0, 32'h0000_0204, 32'h0,         LHU,   4'h3, 1'b0, 32'h0000_ABCD, 1'b0, 32'h0,        32'h0);
    vecs[12] = mk(1'b1, 32'h1000_0000, 32'h0000_00AA, SW,    4'hF, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_00AA, 32'h0);
    vecs[13] = mk(1'b1, 32'h1000_1000, 32'h1234_5655, SB,    4'h1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_00AA, 32'h0000_0055);
    vecs[14] = mk(1'b0, 32'h1000_0000, 32'h0,         LW,    4'hF, 1'b0, 32'h0000_00AA, 1'b0, 32'h0000_00AA, 32'h0000_0055);
    vecs[15] = mk(1'b0, 32'h1000_1000, 32'h0,         LW,    4'hF, 1'b0, 32'h0000_0055, 1'b0, 32'h0000_00AA, 32'h0000_0055);
    vecs[16] = mk(1'b0, 32'h1001_0000, 32'h0,         LW,    4'hF, 1'b0, 32'h0000_1234, 1'b0, 32'h0000_00AA, 32'h0000_0055);
    vecs[17] = mk(1'b1, 32'h1001_0000, 32'hFFFF_FFFF, SW,    4'hF, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_00AA, 32'h0000_0055);
    vecs[18] = mk(1'b0, 32'h2000_0000, 32'h0,         LW,    4'hF, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_00AA, 32'h0000_0055);
    vecs[19] = mk(1'b0, 32'h0000_0100, 32'h0,         3'b011, 4'h0, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_00AA, 32'h0000_0055);

    i_reset_n    = 1'b0;
    i_req_valid  = 1'b0;
    i_req_we     = 1'b0;
    i_req_addr   = '0;
    i_req_wdata  = '0;
    i_req_funct3 = '0;
    i_io_sw      = 32'h0000_1234;

    // Reset state, first cycle after reset release
    repeat (2) @(posedge i_clk);
    #1 i_reset_n = 1'b1;
    @(posedge i_clk); #1;
    check("rst_ready",     32'(o_req_ready), 32'd1);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(o_rsp_err),   32'd0);
    check("rst_rsp_rdata", o_rsp_rdata,      32'd0);
    check("rst_ledr",      o_io_ledr,        32'd0);
    check("rst_ledg",      o_io_ledg,        32'd0);
    check("rst_mem_addr",  32'(o_mem_addr),  32'd0);
    check("rst_mem_wdata", o_mem_wdata,      32'd0);
    check("rst_mem_mask",  32'(o_mem_mask),  32'd0);
    check("rst_mem_wren",  32'(o_mem_wren),  32'd0);

    // Table-driven transactions
    for (int i = 0; i < NVEC; i++) begin
      do_req(i, vecs[i], 1'b0, waited);
    end

    // Request held on valid while busy must be ignored
    v = mk(1'b0, 32'h0000_0204, 32'h0, LW, 4'hF, 1'b0, 32'h0000_ABCD, 1'b0, 32'h0000_00AA, 32'h0000_0055);
    do_req(100, v, 1'b1, waited);

    // Reset during ACCESS of a memory store
    waited = 0;
    while (!o_req_ready && waited < 8) begin
      @(posedge i_clk); #1;
      waited++;
    end
    check("rstop_ready", 32'(o_req_ready), 32'd1);
    i_req_valid  = 1'b1;
    i_req_we     = 1'b1;
    i_req_addr   = 32'h0000_0300;
    i_req_wdata  = 32'hCAFE_F00D;
    i_req_funct3 = SW;
    w0 = wren_cnt;
    @(posedge i_clk); #1;
    i_req_valid = 1'b0;
    check("rstop_wren_before", 32'(o_mem_wren), 32'd1);
    i_reset_n = 1'b0;
    #1;
    check("rstop_wren_gated", 32'(o_mem_wren), 32'd0);
    @(posedge i_clk); #1;
    check("rstop_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rstop_ledr",      o_io_ledr,        32'd0);
    check("rstop_ledg",      o_io_ledg,        32'd0);
    check("rstop_ready",     32'(o_req_ready), 32'd1);
    check("rstop_wren_cycles", 32'(wren_cnt - w0), 32'd0);
    i_reset_n = 1'b1;

    // First ready cycle after reset accepts; the dropped store never landed
    v = mk(1'b0, 32'h0000_0300, 32'h0, LW, 4'hF, 1'b0, 32'h0000_0000, 1'b0, 32'h0, 32'h0);
    do_req(101, v, 1'b0, waited);
    check("rstop_first_accept_wait", 32'(waited), 32'd0);

    repeat (4) @(posedge i_clk);
    #1;
    check("sb_drained",   32'(sb.size()), 32'd0);
    check("rsp_count",    32'(rsp_cnt),   32'(push_cnt));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
